uart_pc_reporter: RTL and testbench
===================================

# uart_pc_reporter

Writer-side framer that serialises the processor's `PC_plus_1` value into a byte frame and pushes it into the UART transmit FIFO through the `wr`/`w_data`/`tx_full` handshake. It sits between `MIPS_DLX` and the UART TX path and is the outbound counterpart to the receive-side command path (`rd`/`r_data`/`rx_empty`). The host uses these frames to observe program progress.

## Interface
Parameters:
- `PC_WIDTH`, 10: width of the reported PC; legal range 9..16.
- `HEADER`, 8'hA5: first byte of every frame.

Ports:
- `clk` input 1: system clock (UART domain clock).
- `reset` input 1: asynchronous, active-low reset.
- `report` input 1: frame request; sampled only in IDLE.
- `pc` input PC_WIDTH: PC value; latched on the accepting edge.
- `tx_full` input 1: UART TX FIFO full flag.
- `wr` output 1: FIFO write strike; one byte is written per `clk` edge with `wr`=1.
- `w_data` output 8: byte presented to the FIFO.
- `busy` output 1: frame in progress (state ≠ IDLE).
- `done` output 1: one-cycle pulse after the last byte is written.

## Operation
- States: IDLE, HDR, PCH, PCL, CHK, DONE.
- IDLE: if `report`=1 at an edge, latch `pc` into `pc_q` and go to HDR. Otherwise stay.
- Byte states (HDR, PCH, PCL, CHK):
  - `w_data` is a combinational mux of state and `pc_q`.
  - `wr` = (byte state) && !`tx_full`. This path is combinational.
  - The state advances only on an edge where `wr`=1. Otherwise it holds and `w_data` stays stable.
- Frame bytes:
  - HDR = `HEADER`.
  - PCH = `pc_q[PC_WIDTH-1:8]`, zero-extended to 8 bits.
  - PCL = `pc_q[7:0]`.
  - CHK = HDR ^ PCH ^ PCL (bitwise XOR).
- Transitions: HDR→PCH→PCL→CHK→DONE. DONE→IDLE unconditionally after one cycle.
- `done`=1 only in DONE. `busy`=1 in every state except IDLE.
- `report` while busy or in DONE is ignored: no queuing, no re-latching of `pc`.
- A `pc` change mid-frame has no effect, because all bytes come from `pc_q`.
- Reset: asynchronous assertion forces IDLE immediately, even mid-frame.
  - Partially sent frames are abandoned; bytes already written stay in the FIFO.
  - Reset values: `wr`=0, `w_data`=8'h00, `busy`=0, `done`=0, `pc_q`=0.
  - `w_data` is 8'h00 in IDLE and DONE.

## Timing
- `report` sampled high at edge E0 → HDR during cycle 1.
- With `tx_full` held low, bytes are written at edges E1..E4 (`wr` high in cycles 1–4) and `done` is high in cycle 5. `busy` is high in cycles 1–5.
- Minimum spacing between accepted requests is 6 cycles: `report` at E0 and again at E6.
- Each cycle with `tx_full`=1 in a byte state adds exactly one cycle of latency. No byte is skipped or duplicated.
- `tx_full` may change in any cycle. `wr` must follow it in the same cycle, with no registered lag.
- `wr` is never high outside a byte state, and never for more than one edge per byte.

## Configuration
- `REPORT_CHECKSUM_EN` defined:
  - Frame is 4 bytes: HDR, PCH, PCL, CHK.
  - Uncontended latency is `report` edge to `done` = 5 cycles.
- `REPORT_CHECKSUM_EN` undefined:
  - CHK is removed; PCL→DONE.
  - Frame is 3 bytes; `done` occurs in cycle 4.
  - No XOR logic is synthesised.

## Test plan
- Basic frame (checksum enabled): `pc`=10'h2A5, `report` pulse, `tx_full`=0 → writes A5, 02, A5, 02 at E1..E4; `done` in cycle 5; `busy` in cycles 1–5.
- Backpressure: same request, `tx_full`=1 during cycles 2–3 → PCH written at E4, full sequence unchanged, `done` in cycle 7, `w_data` stable while stalled.
- Ignored request and PC hold: `report` held high and `pc` changed to 10'h001 during the frame → one frame carrying 10'h2A5; next frame accepted only at an edge in IDLE.
- Reset mid-frame: `reset` low asynchronously after the PCH write → `wr`, `busy`, `done` drop immediately; after release and a new `report` with `pc`=10'h3FF → A5, 03, FF, 59.
- Macro off: `pc`=10'h100, `REPORT_CHECKSUM_EN` undefined → writes A5, 01, 00 at E1..E3; `done` in cycle 4.
- Width: `PC_WIDTH`=16, `pc`=16'hBEEF → A5, BE, EF, F4.

Source files
------------

// File: rtl/uart_pc_reporter.sv
// Frames PC_plus_1 as HEADER, PC high byte, PC low byte [, XOR checksum] into the UART TX FIFO.
// Optional checksum byte is enabled with `define REPORT_CHECKSUM_EN.
module uart_pc_reporter #(
    parameter int          PC_WIDTH = 10,
    parameter logic [7:0]  HEADER   = 8'hA5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                report,
    input  logic [PC_WIDTH-1:0] pc,
    input  logic                tx_full,
    output logic                wr,
    output logic [7:0]          w_data,
    output logic                busy,
    output logic                done
);

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        PCH,
        PCL,
        CHK,
        DONE
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [PC_WIDTH-1:0]   pc_q;
    logic [15:0]           pc_ext;

    assign pc_ext = 16'(pc_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            pc_q  <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && report) begin
                pc_q <= pc;
            end
        end
    end

    // Byte states advance only on an edge where the FIFO actually takes the byte.
    always_comb begin
        state_nxt = state;
        wr        = 1'b0;
        w_data    = 8'h00;
        busy      = 1'b1;
        done      = 1'b0;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (report) begin
                    state_nxt = HDR;
                end
            end
            HDR: begin
                w_data = HEADER;
                wr     = !tx_full;
                if (!tx_full) begin
                    state_nxt = PCH;
                end
            end
            PCH: begin
                w_data = pc_ext[15:8];
                wr     = !tx_full;
                if (!tx_full) begin
                    state_nxt = PCL;
                end
            end
            PCL: begin
                w_data = pc_ext[7:0];
                wr     = !tx_full;
                if (!tx_full) begin
`ifdef REPORT_CHECKSUM_EN
                    state_nxt = CHK;
`else
                    state_nxt = DONE;
`endif
                end
            end
            CHK: begin
`ifdef REPORT_CHECKSUM_EN
                w_data = HEADER ^ pc_ext[15:8] ^ pc_ext[7:0];
                wr     = !tx_full;
                if (!tx_full) begin
                    state_nxt = DONE;
                end
`else
                state_nxt = IDLE;
`endif
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                busy      = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_pc_reporter.sv
// Directed bench for uart_pc_reporter: 10-bit and 16-bit instances, checksum per REPORT_CHECKSUM_EN.
module tb_uart_pc_reporter;

    logic        clk = 1'b0;
    logic        reset;
    logic        report;
    logic [9:0]  pc;
    logic        tx_full;
    logic        wr;
    logic [7:0]  w_data;
    logic        busy;
    logic        done;

    logic        report16;
    logic [15:0] pc16;
    logic        tx_full16;
    logic        wr16;
    logic [7:0]  w_data16;
    logic        busy16;
    logic        done16;

    int unsigned vectors    = 0;
    int unsigned miscompares = 0;

`ifdef REPORT_CHECKSUM_EN
    localparam int NB     = 4;
    localparam int D_BASE = 5;
    localparam int D_BP   = 7;
`else
    localparam int NB     = 3;
    localparam int D_BASE = 4;
    localparam int D_BP   = 6;
`endif

    always #5 clk = ~clk;

    uart_pc_reporter #(.PC_WIDTH(10), .HEADER(8'hA5)) dut (
        .clk(clk), .reset(reset), .report(report), .pc(pc), .tx_full(tx_full),
        .wr(wr), .w_data(w_data), .busy(busy), .done(done)
    );

    uart_pc_reporter #(.PC_WIDTH(16), .HEADER(8'hA5)) dut16 (
        .clk(clk), .reset(reset), .report(report16), .pc(pc16), .tx_full(tx_full16),
        .wr(wr16), .w_data(w_data16), .busy(busy16), .done(done16)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit sel16, input logic rep, input logic full);
        if (sel16) begin
            report16  = rep;
            tx_full16 = full;
        end else begin
            report  = rep;
            tx_full = full;
        end
    endtask

    // Cycle 0 raises report; later cycles apply the stall mask and compare against the expected byte stream.
    task automatic frame(input string tag, input bit sel16, input logic [15:0] pcv,
                         input logic [7:0] b0, input logic [7:0] b1,
                         input logic [7:0] b2, input logic [7:0] b3,
                         input logic [31:0] stall, input bit hold, input int exp_done_cyc);
        logic [7:0] bytes [4];
        int         k;
        bit         fin;
        logic       o_wr, o_busy, o_done, full;
        logic [7:0] o_data;
        bytes[0] = b0; bytes[1] = b1; bytes[2] = b2; bytes[3] = b3;
        k   = 0;
        fin = 1'b0;
        @(negedge clk);
        if (sel16) pc16 = pcv; else pc = 10'(pcv);
        drive(sel16, 1'b1, 1'b0);
        #1;
        check({tag, " idle busy"}, sel16 ? busy16 : busy, 1'b0);
        for (int c = 1; c <= 24 && !fin; c++) begin
            @(negedge clk);
            full = stall[c];
            drive(sel16, hold, full);
            if (hold && c == 2) begin
                if (sel16) pc16 = 16'h0001; else pc = 10'h001;
            end
            #1;
            o_wr   = sel16 ? wr16 : wr;
            o_data = sel16 ? w_data16 : w_data;
            o_busy = sel16 ? busy16 : busy;
            o_done = sel16 ? done16 : done;
            if (k < NB) begin
                check({tag, " wr"}, o_wr, !full);
                check({tag, " w_data"}, o_data, bytes[k]);
                check({tag, " busy"}, o_busy, 1'b1);
                check({tag, " done"}, o_done, 1'b0);
                if (!full) k++;
            end else begin
                check({tag, " done"}, o_done, 1'b1);
                check({tag, " done cycle"}, 16'(c), 16'(exp_done_cyc));
                check({tag, " done wr"}, o_wr, 1'b0);
                check({tag, " done w_data"}, o_data, 8'h00);
                check({tag, " done busy"}, o_busy, 1'b1);
                fin = 1'b1;
            end
        end
        check({tag, " finished in budget"}, 16'(fin), 16'd1);
    endtask

    initial begin
        reset     = 1'b0;
        report    = 1'b0;
        pc        = '0;
        tx_full   = 1'b0;
        report16  = 1'b0;
        pc16      = '0;
        tx_full16 = 1'b0;

        // Reset state
        #12;
        check("rst wr", wr, 1'b0);
        check("rst w_data", w_data, 8'h00);
        check("rst busy", busy, 1'b0);
        check("rst done", done, 1'b0);
        check("rst pc_q", dut.pc_q, 10'h000);
        @(negedge clk);
        reset = 1'b1;

        // Basic uncontended frame
        frame("basic", 1'b0, 16'h02A5, 8'hA5, 8'h02, 8'hA5, 8'h02, 32'h0, 1'b0, D_BASE);
        @(negedge clk); #1;
        check("basic back to idle", busy, 1'b0);

        // Backpressure in cycles 2-3
        frame("bp", 1'b0, 16'h02A5, 8'hA5, 8'h02, 8'hA5, 8'h02, 32'h0000_000C, 1'b0, D_BP);

        // report held and pc changed mid-frame; next frame only from IDLE and carries the new pc
        frame("hold", 1'b0, 16'h02A5, 8'hA5, 8'h02, 8'hA5, 8'h02, 32'h0, 1'b1, D_BASE);
        frame("after hold", 1'b0, 16'h0001, 8'hA5, 8'h00, 8'h01, 8'hA4, 32'h0, 1'b0, D_BASE);

        // Asynchronous reset after the PCH write
        @(negedge clk);
        pc = 10'h2A5; report = 1'b1; tx_full = 1'b0;
        @(negedge clk); report = 1'b0; #1;
        check("rst-mid hdr", w_data, 8'hA5);
        @(negedge clk); #1;
        check("rst-mid pch", w_data, 8'h02);
        @(negedge clk); #1;
        check("rst-mid pcl wr", wr, 1'b1);
        reset = 1'b0;
        #1;
        check("rst-mid wr", wr, 1'b0);
        check("rst-mid busy", busy, 1'b0);
        check("rst-mid done", done, 1'b0);
        check("rst-mid w_data", w_data, 8'h00);
        @(negedge clk);
        reset = 1'b1;
        frame("post reset", 1'b0, 16'h03FF, 8'hA5, 8'h03, 8'hFF, 8'h59, 32'h0, 1'b0, D_BASE);

        // PC with zero low byte
        frame("pc100", 1'b0, 16'h0100, 8'hA5, 8'h01, 8'h00, 8'hA4, 32'h0, 1'b0, D_BASE);

        // 16-bit PC instance
        frame("w16", 1'b1, 16'hBEEF, 8'hA5, 8'hBE, 8'hEF, 8'hF4, 32'h0, 1'b0, D_BASE);
        frame("w16 bp", 1'b1, 16'h1234, 8'hA5, 8'h12, 8'h34, 8'h83, 32'h0000_0012, 1'b0, D_BP);

        @(negedge clk); #1;
        check("end idle busy", busy, 1'b0);
        check("end idle busy16", busy16, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
